// File: rtl/alu_pkg.sv
// alu_pkg: shared funct codes, FSM states and helpers for the multi-cycle ALU.
package alu_pkg;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // 0x18..0x1B share the upper funct bits; bit1 selects divide, bit0 unsigned
    function automatic logic is_muldiv(input logic [5:0] code);
        return code[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response handshake bundle between the datapath stages and the ALU.
interface alu_mc_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [5:0]         alu_code;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_result;
    logic               out_ovf;
    logic               out_dbz;
    logic               out_illegal;

    modport master (
        output in_valid, in_a, in_b, alu_code, shamt, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_dbz, out_illegal
    );

    modport slave (
        input  in_valid, in_a, in_b, alu_code, shamt, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_dbz, out_illegal
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider with sign fix-up.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic               active, div_q, neg_q, neg_r;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc, q, mb, acc_n, q_n, ma, mb_in;
    logic [WIDTH:0]     sum, shl, diff;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic               a_neg, b_neg;

    assign a_neg = is_signed && a[WIDTH-1];
    assign b_neg = is_signed && b[WIDTH-1];
    assign ma    = a_neg ? -a : a;
    assign mb_in = b_neg ? -b : b;
    assign done  = active && cnt == CW'(WIDTH - 1);

    // hi/lo are derived from the step being taken now, so the final values are ready on the done edge
    always_comb begin
        sum    = {1'b0, acc} + {1'b0, mb & {WIDTH{q[0]}}};
        shl    = {acc, q[WIDTH-1]};
        diff   = shl - {1'b0, mb};
        acc_n  = div_q ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
        q_n    = div_q ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
        prod   = {acc_n, q_n};
        prod_s = neg_q ? -prod : prod;
        hi     = div_q ? (neg_r ? -acc_n : acc_n) : prod_s[2*WIDTH-1:WIDTH];
        lo     = div_q ? (dbz ? '1 : (neg_q ? -q_n : q_n)) : prod_s[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            mb     <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            q      <= ma;
            mb     <= mb_in;
            div_q  <= is_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dbz    <= is_div && b == '0;
        end else if (active) begin
            acc    <= acc_n;
            q      <= q_n;
            cnt    <= cnt + 1'b1;
            active <= !done;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS-funct ALU with valid/ready handshakes, HI/LO and iterative mul/div.
module alu_mc import alu_pkg::*; #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst_n,
    alu_mc_if.slave   bus
);
    localparam int M = WIDTH - 1;

    state_t             state, state_d;
    logic [WIDTH-1:0]   a, b, sum, diff, res, hi, lo, md_hi, md_lo, result_q;
    logic [SHAMT_W-1:0] sh;
    logic               fire, md_op, md_done, md_dbz, ovf, ill, ovf_q, dbz_q, ill_q;

    assign a     = bus.in_a;
    assign b     = bus.in_b;
    assign sh    = bus.shamt;
    assign md_op = is_muldiv(bus.alu_code);
    assign fire  = bus.in_valid && bus.in_ready;
    assign sum   = a + b;
    assign diff  = a - b;

    assign bus.in_ready    = rst_n && state == IDLE;
    assign bus.out_valid   = state == RESP;
    assign bus.out_result  = result_q;
    assign bus.out_ovf     = ovf_q;
    assign bus.out_dbz     = dbz_q;
    assign bus.out_illegal = ill_q;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (fire && md_op),
        .is_div    (bus.alu_code[1]),
        .is_signed (!bus.alu_code[0]),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo),
        .dbz       (md_dbz)
    );

    always_comb begin
        res = '0;
        ovf = 1'b0;
        ill = 1'b0;
        case (bus.alu_code)
            FN_ADD: begin
                res = sum;
                ovf = a[M] == b[M] && sum[M] != a[M];
            end
            FN_SUB: begin
                res = diff;
                ovf = a[M] != b[M] && diff[M] != a[M];
            end
            FN_AND:  res = a & b;
            FN_OR:   res = a | b;
            FN_XOR:  res = a ^ b;
            FN_NOR:  res = ~(a | b);
            FN_SLT:  res = {{M{1'b0}}, $signed(a) < $signed(b)};
            FN_SLTU: res = {{M{1'b0}}, a < b};
            FN_SLL:  res = a << sh;
            FN_SRL:  res = a >> sh;
            FN_SRA:  res = $signed(a) >>> sh;
            FN_MFHI: res = hi;
            FN_MFLO: res = lo;
            default: ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (fire) state_d = md_op ? BUSY : RESP;
            BUSY:    if (md_done) state_d = RESP;
            RESP:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        state <= rst_n ? state_d : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else if (state == BUSY && md_done) begin
            hi       <= md_hi;
            lo       <= md_lo;
            result_q <= md_lo;
            ovf_q    <= 1'b0;
            dbz_q    <= md_dbz;
            ill_q    <= 1'b0;
        end else if (fire && !md_op) begin
            result_q <= res;
            ovf_q    <= ovf;
            dbz_q    <= 1'b0;
            ill_q    <= ill;
        end
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the team's combinational MIPS-funct ALU.
- Executes R-type funct codes behind valid/ready handshakes on both sides.
- Adds SLT/SLTU/XOR/NOR, plus iterative MULT/MULTU/DIV/DIVU with internal HI/LO registers and MFHI/MFLO.
- Sits between the decode/register-read stage and writeback in the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width (even, >=8).
- SHAMT_W, $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request; equals rst_n && state==IDLE (combinational).
- in_a  in  WIDTH  operand A (rs).
- in_b  in  WIDTH  operand B (rt).
- alu_code  in  6  MIPS funct code.
- shamt  in  SHAMT_W  shift amount.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  result.
- out_ovf  out  1  signed overflow (ADD/SUB only).
- out_dbz  out  1  divide by zero (DIV/DIVU only).
- out_illegal  out  1  unsupported alu_code.

Behaviour:
- Reset (clk edge with rst_n=0): state=IDLE, out_valid=0, out_result=0, all flags=0, HI=LO=0, iteration counter=0. Reset mid-BUSY or mid-RESP aborts the operation; that result is never presented.
- Handshake:
  - Request is accepted on an edge with in_valid && in_ready.
  - Operands and code are latched on acceptance; inputs are don't-care afterwards.
  - Result transfers on an edge with out_valid && out_ready.
  - out_result and flags stay stable while out_valid=1 && out_ready=0.
- FSM:
  - IDLE: accept a request. MULT/MULTU/DIV/DIVU -> BUSY; every other code -> RESP.
  - BUSY: iterate. After exactly WIDTH iteration cycles, go to RESP.
  - RESP: out_valid=1. On out_ready, go to IDLE.
- Latency:
  - Single-cycle codes: out_valid rises 1 edge after acceptance.
  - MULT/MULTU/DIV/DIVU: out_valid rises WIDTH+1 edges after acceptance.
  - Peak throughput: one op per 2 cycles (no accept in RESP).
- Codes (result width WIDTH; wrap modulo 2^WIDTH):
  - 0x20 ADD: A+B. ovf = sign(A)==sign(B) && sign(sum)!=sign(A).
  - 0x22 SUB: A-B. ovf = sign(A)!=sign(B) && sign(diff)!=sign(A).
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR: bitwise.
  - 0x2A SLT: signed A<B ? 1 : 0. 0x2B SLTU: unsigned compare, same encoding.
  - 0x00 SLL: A<<shamt. 0x02 SRL: A>>shamt, zero fill. 0x03 SRA: A>>shamt, sign fill.
  - 0x18 MULT, 0x19 MULTU: shift-add, 1 bit per cycle. {HI,LO} = 2*WIDTH product.
    - Signed: multiply magnitudes, negate the product if sign(A)^sign(B).
  - 0x1A DIV, 0x1B DIVU: restoring divide, 1 bit per cycle. LO=quotient, HI=remainder.
    - Signed: quotient negative iff signs differ; remainder takes the sign of A.
    - B==0: no iteration shortcut (still WIDTH cycles). LO=all-ones, HI=A, dbz=1.
  - Result/commit for MULT/MULTU/DIV/DIVU: out_result=LO. HI/LO commit on the BUSY->RESP edge.
  - 0x10 MFHI: result=HI. 0x12 MFLO: result=LO.
  - Any other code: result=0, illegal=1, HI/LO unchanged.
- Flags not listed for a code are 0.
- Signed MULT with A=B=most-negative: magnitude is 2^(WIDTH-1), which must be representable in the internal datapath. Product is +2^(2*WIDTH-2).
- Signed DIV most-negative/-1: quotient wraps to most-negative, remainder 0, no flag.

Decomposition:
- Shared package alu_pkg:
  - Funct-code localparams (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MFLO).
  - FSM state enum (IDLE, BUSY, RESP).
- One sub-module alu_muldiv_iter:
  - Holds the iterative multiply/divide datapath, counter and sign fix-up.
  - Interface: start, is_div, is_signed, a, b -> done, hi, lo, dbz.
- The top level holds the FSM, the single-cycle datapath, HI/LO and the output register.

Test Plan:
- Reset then single-cycle ops, WIDTH=32, out_ready=1:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
  - SUB 5-7 -> 0xFFFFFFFE, ovf=0.
  - SRA 0x80000000 by 4 -> 0xF8000000. SRL same -> 0x08000000.
  - SLT 0xFFFFFFFF vs 1 -> 1. SLTU same -> 0.
  - Each out_valid exactly 1 edge after accept.
- MULT -3 x 7 -> out_valid at edge 33. Result 0xFFFFFFEB. Then MFHI -> 0xFFFFFFFF, MFLO -> 0xFFFFFFEB. MULTU 0xFFFFFFFF x 2 -> HI=1, LO=0xFFFFFFFE.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7, dbz=1, latency 33.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid: result and flags stable, in_ready=0 throughout.
  - in_valid asserted during BUSY is ignored.
- Reset mid-BUSY: rst_n=0 at iteration 10 of DIV.
  - Next cycle: state IDLE, out_valid=0, HI=LO=0.
  - Following MFLO -> 0.
- Illegal code 0x3F -> result 0, illegal=1, HI/LO preserved. Re-run a sweep with WIDTH=8: MULTU 0xFF x 0xFF -> HI=0xFE, LO=0x01, latency 9.
